z80_blkxfer_seq: RTL and testbench
==================================

Name: z80_blkxfer_seq

Overview:
- Sequencer for the Z80 block-transfer group: LDI, LDD, LDIR and LDDR.
- On a start pulse it runs one iteration of the transfer:
  - memory read at HL, then memory write at DE;
  - two extended T-states;
  - an optional 5-T internal cycle when the instruction repeats.
- It produces the updated HL/DE/BC/F/IP for the register file.
- It sits between the instruction decoder (ED A0/A8/B0/B8) and the bus M-cycle controller. It owns the memory request handshake for the duration of the instruction.

Parameters:
- EXT_T, 2, number of extended T-states after the write M-cycle.
- REP_T, 5, number of T-states in the repeat internal cycle.

Ports:
- clk  in  1  core clock, one tick per T-state
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin one iteration; sampled only in IDLE
- mode_dec  in  1  1 = decrement HL/DE (LDD/LDDR), 0 = increment (LDI/LDIR)
- mode_rep  in  1  1 = repeating form (LDIR/LDDR)
- hl_in  in  16  source address
- de_in  in  16  destination address
- bc_in  in  16  byte count
- f_in  in  8  flags before the instruction
- a_in  in  8  accumulator; used only with the optional feature
- ip_in  in  16  address of the ED prefix byte
- mem_req  out  1  memory cycle request to the bus controller
- mem_we  out  1  1 = write cycle, 0 = read cycle
- mem_addr  out  16  memory address
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, valid when mem_ack=1 on a read
- mem_ack  in  1  bus controller completes the current cycle
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse; the *_out ports are valid this cycle and stay held until the next start
- hl_out, de_out, bc_out  out  16 each  updated register pair values
- f_out  out  8  updated flags
- ip_out  out  16  next instruction pointer
- repeat_out  out  1  1 = instruction will re-execute (ip_out = ip_in)

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; every output is 0; the internal data latch and T-counter are 0.
- States: IDLE -> RD -> WR -> EXT -> [REP] -> DONE -> IDLE.
- IDLE:
  - start=1 latches all inputs and moves to RD next cycle; busy rises with RD.
  - start while busy is ignored.
- RD:
  - drives mem_req=1, mem_we=0, mem_addr=latched HL;
  - holds until mem_ack=1, which latches mem_rdata and moves to WR.
- WR:
  - drives mem_req=1, mem_we=1, mem_addr=latched DE, mem_wdata=latched byte;
  - mem_ack=1 moves to EXT.
  - mem_req is low in every other state.
  - There is no bubble between RD and WR: mem_req stays high across the ack edge.
- EXT:
  - counts EXT_T cycles.
  - If mode_rep=1 and bc_new != 0, go to REP; otherwise go to DONE.
- REP: counts REP_T cycles, then goes to DONE.
- DONE: done=1 for one cycle; busy=0 from DONE onward; returns to IDLE.
- Arithmetic (all modulo 2^16):
  - hl_new = HL ± 1, de_new = DE ± 1 (minus when mode_dec=1);
  - bc_new = BC − 1. bc_in = 0 wraps to FFFF, which means 65536 transfers.
- Flags (S7 Z6 Y5 H4 X3 PV2 N1 C0):
  - H=0, N=0, PV = (bc_new != 0);
  - S, Z, C and Y/X (without the feature) are copied from f_in.
- IP:
  - repeat_out = mode_rep & (bc_new != 0);
  - ip_out = repeat_out ? ip_in : ip_in + 2.
- Total T-states with zero-wait acks:
  - non-repeat: 1 + 1 + 1 + EXT_T + 1 = 6 clocks from start to done;
  - repeat: 6 + REP_T = 11.
- Overlap: HL = DE is legal; addresses are latched at start, so nothing special is done.
- Reset mid-operation: reset during RD or WR drops mem_req immediately (asynchronously) with no partial update. Outputs keep their reset values until a fresh start.

Optional Feature:
- Macro: Z80_BLKXFER_UNDOC_FLAGS_EN.
- Defined: n = latched byte + a_in (8-bit); f_out[5] = n[1], f_out[3] = n[3] (undocumented Y/X).
- Undefined: a_in is unused and f_out[5], f_out[3] copy f_in.

Decomposition:
- Shared package: state enum, flag bit-index constants (FLAG_S..FLAG_C), mask constants.
- One sub-module, z80_blkxfer_regcalc: combinational next HL/DE/BC/F/IP from the latched values and the mode bits. The FSM and handshake stay in the top module.

Test Plan:
- LDI: HL=1000, DE=2000, BC=0003, F=FF, mem[1000]=5A, zero-wait acks -> write 5A@2000; HL=1001, DE=2001, BC=0002; F=ED (H,N clear, PV=1); ip_out=ip_in+2; done 6 clocks after start.
- LDDR last iteration: BC=0001, HL=1000, DE=2000, F=04 -> HL=0FFF, DE=1FFF, BC=0000, F=00, repeat_out=0, no REP cycle, ip_out=ip_in+2.
- LDDR continuing: BC=0005 -> BC=0004, PV=1, repeat_out=1, ip_out=ip_in, done 11 clocks after start.
- Wrap and wait states: HL=FFFF, DE=0000, BC=0000, LDI, mem_ack delayed 3 cycles on both read and write -> HL=0000, DE=0001, BC=FFFF, PV=1; mem_req held steady through the waits.
- Reset asserted while in WR with mem_ack low -> mem_req, busy and done drop immediately; next start completes normally.
- With Z80_BLKXFER_UNDOC_FLAGS_EN: byte=0A, A=00 -> n=0A; f_out[5]=1, f_out[3]=1. Without the macro: both bits equal f_in.

Source files
------------

// File: rtl/z80_blkxfer_seq_pkg.sv
// Shared definitions for the Z80 block-transfer sequencer: FSM encodings,
// flag bit positions and masks, and the result bundle produced by the regcalc.
package z80_blkxfer_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_RD   = 3'd1;
  localparam state_t S_WR   = 3'd2;
  localparam state_t S_EXT  = 3'd3;
  localparam state_t S_REP  = 3'd4;
  localparam state_t S_DONE = 3'd5;

  localparam int FLAG_S  = 7;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_Y  = 5;
  localparam int FLAG_H  = 4;
  localparam int FLAG_X  = 3;
  localparam int FLAG_PV = 2;
  localparam int FLAG_N  = 1;
  localparam int FLAG_C  = 0;

  localparam logic [7:0] FMASK_Y  = 8'h20;
  localparam logic [7:0] FMASK_H  = 8'h10;
  localparam logic [7:0] FMASK_X  = 8'h08;
  localparam logic [7:0] FMASK_PV = 8'h04;
  localparam logic [7:0] FMASK_N  = 8'h02;

  typedef struct packed {
    logic [15:0] hl;
    logic [15:0] de;
    logic [15:0] bc;
    logic [7:0]  f;
    logic [15:0] ip;
    logic        rep;
  } regs_t;

  function automatic logic [15:0] step16(input logic [15:0] v, input logic dec);
    return dec ? v - 16'd1 : v + 16'd1;
  endfunction

endpackage

// File: rtl/z80_blkxfer_seq_if.sv
// Memory-cycle handshake between the block-transfer sequencer (master)
// and the bus M-cycle controller (slave).
interface z80_blkxfer_seq_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ack);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ack);
endinterface

// File: rtl/z80_blkxfer_seq_regcalc.sv
// Combinational register-file update for LDI/LDD/LDIR/LDDR.
// Z80_BLKXFER_UNDOC_FLAGS_EN derives Y/X from (byte + A) as real silicon does.
module z80_blkxfer_regcalc
  import z80_blkxfer_seq_pkg::*;
(
  input  logic        i_mode_dec,
  input  logic        i_mode_rep,
  input  logic [15:0] i_hl,
  input  logic [15:0] i_de,
  input  logic [15:0] i_bc,
  input  logic [15:0] i_ip,
  input  logic [7:0]  i_f,
  input  logic [7:0]  i_byte,
  input  logic [7:0]  i_a,
  output regs_t       o_regs
);

  logic [15:0] w_bc_new;
  logic        w_bc_nz;
  logic        w_rep;
  logic [7:0]  w_f;

  assign w_bc_new = i_bc - 16'd1;
  assign w_bc_nz  = (w_bc_new != 16'd0);
  assign w_rep    = i_mode_rep & w_bc_nz;

`ifdef Z80_BLKXFER_UNDOC_FLAGS_EN
  logic [7:0] w_n;
  assign w_n = i_byte + i_a;
`else
  logic w_unused_byte_a;
  assign w_unused_byte_a = ^{i_byte, i_a};
`endif

  always_comb begin
    w_f = i_f & ~(FMASK_H | FMASK_N | FMASK_PV);
    w_f[FLAG_PV] = w_bc_nz;
`ifdef Z80_BLKXFER_UNDOC_FLAGS_EN
    w_f[FLAG_Y] = w_n[1];
    w_f[FLAG_X] = w_n[3];
`endif
  end

  assign o_regs.hl  = step16(i_hl, i_mode_dec);
  assign o_regs.de  = step16(i_de, i_mode_dec);
  assign o_regs.bc  = w_bc_new;
  assign o_regs.f   = w_f;
  assign o_regs.ip  = w_rep ? i_ip : i_ip + 16'd2;
  assign o_regs.rep = w_rep;

endmodule

// File: rtl/z80_blkxfer_seq.sv
// Z80 block-transfer sequencer: read (HL), write (DE), extended T-states and
// optional repeat cycle. Optional macro: Z80_BLKXFER_UNDOC_FLAGS_EN.
module z80_blkxfer_seq
  import z80_blkxfer_seq_pkg::*;
#(
  parameter int EXT_T = 2,
  parameter int REP_T = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode_dec,
  input  logic                mode_rep,
  input  logic [15:0]         hl_in,
  input  logic [15:0]         de_in,
  input  logic [15:0]         bc_in,
  input  logic [7:0]          f_in,
  input  logic [7:0]          a_in,
  input  logic [15:0]         ip_in,
  z80_blkxfer_seq_if.master   mem,
  output logic                busy,
  output logic                done,
  output logic [15:0]         hl_out,
  output logic [15:0]         de_out,
  output logic [15:0]         bc_out,
  output logic [7:0]          f_out,
  output logic [15:0]         ip_out,
  output logic                repeat_out
);

  state_t      r_state;
  logic [7:0]  r_tcnt;
  logic        r_mode_dec, r_mode_rep;
  logic [15:0] r_hl, r_de, r_bc, r_ip;
  logic [7:0]  r_f, r_a, r_byte;
  regs_t       r_res;
  regs_t       w_calc;
  logic        w_ext_last, w_rep_last, w_finish;

  z80_blkxfer_regcalc u_regcalc (
    .i_mode_dec (r_mode_dec),
    .i_mode_rep (r_mode_rep),
    .i_hl       (r_hl),
    .i_de       (r_de),
    .i_bc       (r_bc),
    .i_ip       (r_ip),
    .i_f        (r_f),
    .i_byte     (r_byte),
    .i_a        (r_a),
    .o_regs     (w_calc)
  );

  assign w_ext_last = (r_tcnt == 8'(EXT_T - 1));
  assign w_rep_last = (r_tcnt == 8'(REP_T - 1));
  assign w_finish   = ((r_state == S_EXT) && w_ext_last && !w_calc.rep) ||
                      ((r_state == S_REP) && w_rep_last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tcnt     <= 8'd0;
      r_mode_dec <= 1'b0;
      r_mode_rep <= 1'b0;
      r_hl       <= 16'd0;
      r_de       <= 16'd0;
      r_bc       <= 16'd0;
      r_ip       <= 16'd0;
      r_f        <= 8'd0;
      r_a        <= 8'd0;
      r_byte     <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_mode_dec <= mode_dec;
          r_mode_rep <= mode_rep;
          r_hl       <= hl_in;
          r_de       <= de_in;
          r_bc       <= bc_in;
          r_ip       <= ip_in;
          r_f        <= f_in;
          r_a        <= a_in;
          r_state    <= S_RD;
        end
        S_RD: if (mem.mem_ack) begin
          r_byte  <= mem.mem_rdata;
          r_state <= S_WR;
        end
        S_WR: if (mem.mem_ack) begin
          r_tcnt  <= 8'd0;
          r_state <= S_EXT;
        end
        S_EXT: begin
          if (w_ext_last) begin
            r_tcnt  <= 8'd0;
            r_state <= w_calc.rep ? S_REP : S_DONE;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        S_REP: begin
          if (w_rep_last) begin
            r_tcnt  <= 8'd0;
            r_state <= S_DONE;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Results are captured on entry to DONE and held until the next completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_res <= '0;
    end else if (w_finish) begin
      r_res <= w_calc;
    end
  end

  assign mem.mem_req   = (r_state == S_RD) || (r_state == S_WR);
  assign mem.mem_we    = (r_state == S_WR);
  assign mem.mem_addr  = (r_state == S_RD) ? r_hl :
                         (r_state == S_WR) ? r_de : 16'd0;
  assign mem.mem_wdata = (r_state == S_WR) ? r_byte : 8'd0;

  assign busy       = (r_state == S_RD) || (r_state == S_WR) ||
                      (r_state == S_EXT) || (r_state == S_REP);
  assign done       = (r_state == S_DONE);
  assign hl_out     = r_res.hl;
  assign de_out     = r_res.de;
  assign bc_out     = r_res.bc;
  assign f_out      = r_res.f;
  assign ip_out     = r_res.ip;
  assign repeat_out = r_res.rep;

endmodule

// File: tb/tb_z80_blkxfer_seq.sv
// Directed bench for z80_blkxfer_seq with a wait-state bus responder.
module tb_z80_blkxfer_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start, mode_dec, mode_rep;
  logic [15:0] hl_in, de_in, bc_in, ip_in;
  logic [7:0]  f_in, a_in;
  logic        busy, done, repeat_out;
  logic [15:0] hl_out, de_out, bc_out, ip_out;
  logic [7:0]  f_out;

  int          checks = 0;
  int          failures = 0;
  int          wait_n = 0;
  int          wcnt = 0;
  int          nwr = 0;
  logic [7:0]  rd_byte = 8'h00;
  logic [15:0] last_raddr = 16'h0;
  logic [15:0] last_waddr = 16'h0;
  logic [7:0]  last_wdata = 8'h0;

  int          dn_cyc;
  bit          bubble;
  bit          busy_at2;

  z80_blkxfer_seq_if bus ();

  z80_blkxfer_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode_dec   (mode_dec),
    .mode_rep   (mode_rep),
    .hl_in      (hl_in),
    .de_in      (de_in),
    .bc_in      (bc_in),
    .f_in       (f_in),
    .a_in       (a_in),
    .ip_in      (ip_in),
    .mem        (bus),
    .busy       (busy),
    .done       (done),
    .hl_out     (hl_out),
    .de_out     (de_out),
    .bc_out     (bc_out),
    .f_out      (f_out),
    .ip_out     (ip_out),
    .repeat_out (repeat_out)
  );

  always #5 clk = ~clk;

  assign bus.mem_ack   = bus.mem_req && (wcnt == wait_n);
  assign bus.mem_rdata = rd_byte;

  always @(posedge clk) begin
    if (bus.mem_req && !bus.mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
      last_waddr <= bus.mem_addr;
      last_wdata <= bus.mem_wdata;
      nwr        <= nwr + 1;
    end
    if (bus.mem_req && bus.mem_ack && !bus.mem_we) last_raddr <= bus.mem_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulses start and counts cycles inclusively from the start cycle to the done cycle.
  task automatic run(input int poke_at);
    int  n;
    bit  seen, fell;
    @(negedge clk);
    start = 1'b1;
    n = 1; dn_cyc = 0; bubble = 0; seen = 0; fell = 0; busy_at2 = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (n == 2) begin start = 1'b0; busy_at2 = busy; end
      if (n == poke_at) begin start = 1'b1; hl_in = 16'hAAAA; end
      if (n == poke_at + 1) start = 1'b0;
      if (bus.mem_req) begin
        if (fell) bubble = 1;
        seen = 1;
      end else if (seen) fell = 1;
      if (done) begin dn_cyc = n; break; end
    end
    start = 1'b0;
    if (dn_cyc == 0) check("done_timeout", 32'(n), 32'(0));
  endtask

  task automatic check_res(input string tag, input logic [15:0] hl, input logic [15:0] de,
                           input logic [15:0] bc, input logic [7:0] f, input logic [15:0] ip,
                           input logic rep, input int cyc);
    check({tag, "_hl"}, 32'(hl_out), 32'(hl));
    check({tag, "_de"}, 32'(de_out), 32'(de));
    check({tag, "_bc"}, 32'(bc_out), 32'(bc));
    check({tag, "_f"},  32'(f_out),  32'(f));
    check({tag, "_ip"}, 32'(ip_out), 32'(ip));
    check({tag, "_rep"}, 32'(repeat_out), 32'(rep));
    check({tag, "_cyc"}, 32'(dn_cyc), 32'(cyc));
  endtask

  task automatic setup(input logic dec, input logic rep, input logic [15:0] hl,
                       input logic [15:0] de, input logic [15:0] bc, input logic [7:0] f,
                       input logic [15:0] ip, input logic [7:0] b, input int w);
    mode_dec = dec; mode_rep = rep; hl_in = hl; de_in = de; bc_in = bc;
    f_in = f; ip_in = ip; rd_byte = b; wait_n = w;
  endtask

  initial begin
    int nwr0, k;
    logic [7:0] undoc_f;
    start = 0; mode_dec = 0; mode_rep = 0; hl_in = 0; de_in = 0; bc_in = 0;
    f_in = 0; a_in = 0; ip_in = 0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req",  32'(bus.mem_req), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_hl",   32'(hl_out), 32'(0));
    check("rst_ip",   32'(ip_out), 32'(0));
    check("rst_f",    32'(f_out), 32'(0));
    reset = 1'b0;

    // LDI
    setup(0, 0, 16'h1000, 16'h2000, 16'h0003, 8'hFF, 16'h0100, 8'h5A, 0);
    nwr0 = nwr;
    run(0);
    check_res("ldi", 16'h1001, 16'h2001, 16'h0002, 8'hED, 16'h0102, 1'b0, 6);
    check("ldi_busy_rd", 32'(busy_at2), 32'(1));
    check("ldi_busy_done", 32'(busy), 32'(0));
    check("ldi_raddr", 32'(last_raddr), 32'h1000);
    check("ldi_waddr", 32'(last_waddr), 32'h2000);
    check("ldi_wdata", 32'(last_wdata), 32'h5A);
    check("ldi_nwr", 32'(nwr - nwr0), 32'(1));
    @(negedge clk);
    check("ldi_done_pulse", 32'(done), 32'(0));
    check("ldi_hold_hl", 32'(hl_out), 32'h1001);

    // LDDR, last iteration
    setup(1, 1, 16'h1000, 16'h2000, 16'h0001, 8'h04, 16'h0200, 8'h11, 0);
    run(0);
    check_res("lddr_last", 16'h0FFF, 16'h1FFF, 16'h0000, 8'h00, 16'h0202, 1'b0, 6);

    // LDDR continuing, with a start pulse while busy that must be ignored
    setup(1, 1, 16'h3000, 16'h4000, 16'h0005, 8'h00, 16'h0300, 8'hC3, 0);
    run(4);
    check_res("lddr_cont", 16'h2FFF, 16'h3FFF, 16'h0004, 8'h04, 16'h0300, 1'b1, 11);
    check("lddr_waddr", 32'(last_waddr), 32'h4000);
    check("lddr_wdata", 32'(last_wdata), 32'hC3);

    // Address/count wrap with 3 wait states on read and write
    setup(0, 0, 16'hFFFF, 16'h0000, 16'h0000, 8'h00, 16'hFFFE, 8'h77, 3);
    run(0);
    check_res("wrap", 16'h0000, 16'h0001, 16'hFFFF, 8'h04, 16'h0000, 1'b0, 12);
    check("wrap_no_bubble", 32'(bubble), 32'(0));
    check("wrap_raddr", 32'(last_raddr), 32'hFFFF);
    check("wrap_waddr", 32'(last_waddr), 32'h0000);
    check("wrap_wdata", 32'(last_wdata), 32'h77);

    // Asynchronous reset while the write cycle is waiting for ack
    setup(0, 0, 16'h4000, 16'h4100, 16'h0009, 8'h00, 16'h0400, 8'h3C, 3);
    nwr0 = nwr;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(bus.mem_req && bus.mem_we) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid_reached_wr", 32'(bus.mem_we), 32'(1));
    #2 reset = 1'b1;
    #1;
    check("rst_mid_req",  32'(bus.mem_req), 32'(0));
    check("rst_mid_busy", 32'(busy), 32'(0));
    check("rst_mid_done", 32'(done), 32'(0));
    check("rst_mid_hl",   32'(hl_out), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_nwr", 32'(nwr - nwr0), 32'(0));
    setup(0, 0, 16'h1234, 16'h5678, 16'h0010, 8'h00, 16'h0010, 8'h99, 0);
    run(0);
    check_res("after_rst", 16'h1235, 16'h5679, 16'h000F, 8'h04, 16'h0012, 1'b0, 6);
    check("after_rst_wdata", 32'(last_wdata), 32'h99);

    // Undocumented Y/X: byte 0A + A 00 = 0A -> bit1=1, bit3=1
`ifdef Z80_BLKXFER_UNDOC_FLAGS_EN
    undoc_f = 8'h2C;
`else
    undoc_f = 8'h04;
`endif
    a_in = 8'h00;
    setup(0, 0, 16'h5000, 16'h6000, 16'h0002, 8'h00, 16'h0500, 8'h0A, 0);
    run(0);
    check_res("undoc", 16'h5001, 16'h6001, 16'h0001, undoc_f, 16'h0502, 1'b0, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
